// File: rtl/census_hamming_cost.sv
// Census matching cost: per left pixel, Hamming distance to the right pixel at every
// disparity 0..DISP_RANGE-1. Two registered stages (XOR/valid, then popcount).
module census_hamming_cost #(
  parameter int CENSUS_W   = 8,
  parameter int DISP_RANGE = 64,
  parameter int COST_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         de_in,
  input  logic                         h_sync_in,
  input  logic                         v_sync_in,
  input  logic [CENSUS_W-1:0]          census_left,
  input  logic [CENSUS_W-1:0]          census_right,
  output logic                         clk_out,
  output logic                         de_out,
  output logic                         h_sync_out,
  output logic                         v_sync_out,
  output logic [DISP_RANGE*COST_W-1:0] cost_out
);

  localparam int COL_W = $clog2(DISP_RANGE) + 1;

  logic [CENSUS_W-1:0]          hist_q [1:DISP_RANGE-1];
  logic [CENSUS_W-1:0]          hist_d [1:DISP_RANGE-1];
  logic [COL_W-1:0]             col_q, col_d;
  logic [CENSUS_W-1:0]          x_q [DISP_RANGE];
  logic [CENSUS_W-1:0]          x_d [DISP_RANGE];
  logic [DISP_RANGE-1:0]        vld_q, vld_d;
  logic [DISP_RANGE*COST_W-1:0] cost_q, cost_d;
  // sync vectors are {v_sync, h_sync, de}
  logic [2:0]                   sync1_q, sync1_d;
  logic [2:0]                   sync2_q, sync2_d;

  function automatic logic [COST_W-1:0] popcnt(input logic [CENSUS_W-1:0] v);
    logic [COST_W-1:0] c;
    c = '0;
    for (int i = 0; i < CENSUS_W; i++) c = c + COST_W'(v[i]);
    return c;
  endfunction

  always_comb begin
    hist_d = hist_q;
    col_d  = '0;
    if (de_in) begin
      hist_d[1] = census_right;
      for (int k = 2; k < DISP_RANGE; k++) hist_d[k] = hist_q[k-1];
      col_d = (col_q == COL_W'(DISP_RANGE)) ? col_q : col_q + 1'b1;
    end
  end

  // Stale history beyond the current column is masked by vld, never cleared.
  always_comb begin
    x_d[0]   = census_left ^ census_right;
    vld_d[0] = 1'b1;
    for (int d = 1; d < DISP_RANGE; d++) begin
      x_d[d]   = census_left ^ hist_q[d];
      vld_d[d] = (col_q >= COL_W'(d));
    end
    sync1_d = {v_sync_in, h_sync_in, de_in};
  end

  always_comb begin
    cost_d = '0;
    for (int d = 0; d < DISP_RANGE; d++)
      cost_d[d*COST_W +: COST_W] = vld_q[d] ? popcnt(x_q[d]) : COST_W'(CENSUS_W);
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < DISP_RANGE; k++) hist_q[k] <= '0;
      for (int d = 0; d < DISP_RANGE; d++) x_q[d] <= '0;
      col_q   <= '0;
      vld_q   <= '0;
      cost_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      hist_q  <= hist_d;
      x_q     <= x_d;
      col_q   <= col_d;
      vld_q   <= vld_d;
      cost_q  <= cost_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign clk_out    = clk;
  assign de_out     = sync2_q[0];
  assign h_sync_out = sync2_q[1];
  assign v_sync_out = sync2_q[2];
  assign cost_out   = cost_q;

endmodule

// File: tb/tb_census_hamming_cost.sv
// Directed bench for census_hamming_cost: reset, identical streams, shift, complement,
// line restart and mid-line reset, with closed-form expected cost vectors.
module tb_census_hamming_cost;

  localparam int CW = 8;
  localparam int DR = 64;
  localparam int KW = 4;
  localparam int VW = DR * KW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          de_in, h_sync_in, v_sync_in;
  logic [CW-1:0] census_left, census_right;
  logic          clk_out, de_out, h_sync_out, v_sync_out;
  logic [VW-1:0] cost_out;

  logic [VW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          d1_de = 1'b0, d1_hs = 1'b0, d1_vs = 1'b0;

  census_hamming_cost #(.CENSUS_W(CW), .DISP_RANGE(DR), .COST_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .census_left(census_left), .census_right(census_right), .clk_out(clk_out),
    .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .cost_out(cost_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [CW-1:0] left_val(input int scen, input int n);
    case (scen)
      3:       return 8'(n - 5);
      4:       return 8'hFF;
      5:       return 8'(n + 1);
      default: return 8'hA5;
    endcase
  endfunction

  function automatic logic [CW-1:0] right_val(input int scen, input int k);
    case (scen)
      3:       return 8'(k);
      4:       return 8'h00;
      5:       return 8'(k + 1);
      default: return 8'hA5;
    endcase
  endfunction

  // Disparity d is valid for pixel n when d <= n; invalid ones read as CENSUS_W.
  function automatic logic [VW-1:0] exp_vec(input int scen, input int n);
    logic [VW-1:0] v;
    v = '0;
    for (int d = 0; d < DR; d++)
      v[d*KW +: KW] = (d <= n) ?
        KW'($countones(left_val(scen, n) ^ right_val(scen, n - d))) : KW'(CW);
    return v;
  endfunction

  task automatic step(input logic de, input int scen, input int n, input logic hs, input logic vs);
    de_in        = de;
    h_sync_in    = hs;
    v_sync_in    = vs;
    census_left  = de ? left_val(scen, n)  : 8'($urandom_range(0, 255));
    census_right = de ? right_val(scen, n) : 8'($urandom_range(0, 255));
    if (de) exp_q.push_back(exp_vec(scen, n));
    @(posedge clk);
    #1;
    check("de_out", VW'(de_out), VW'(d1_de));
    check("h_sync_out", VW'(h_sync_out), VW'(d1_hs));
    check("v_sync_out", VW'(v_sync_out), VW'(d1_vs));
    if (d1_de) begin
      if (exp_q.size() == 0) check("cost_queue_empty", VW'(1), VW'(0));
      else check($sformatf("cost s%0d", scen), cost_out, exp_q.pop_front());
    end
    d1_de = de;
    d1_hs = hs;
    d1_vs = vs;
  endtask

  task automatic run_line(input int scen, input int len);
    for (int n = 0; n < len; n++) step(1'b1, scen, n, 1'b0, 1'b0);
  endtask

  task automatic gap(input int cycles, input logic noisy);
    for (int i = 0; i < cycles; i++)
      step(1'b0, 0, 0, noisy & 1'($urandom_range(0, 1)), noisy & 1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " de"}, VW'(de_out), '0);
    check({tag, " hs"}, VW'(h_sync_out), '0);
    check({tag, " vs"}, VW'(v_sync_out), '0);
    check({tag, " cost"}, cost_out, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
    census_left = '0; census_right = '0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      de_in        = 1'($urandom_range(0, 1));
      h_sync_in    = 1'($urandom_range(0, 1));
      v_sync_in    = 1'($urandom_range(0, 1));
      census_left  = 8'($urandom_range(0, 255));
      census_right = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check_all_zero("in_reset");
    end
    rst_n = 1'b1;
    gap(3, 1'b0);

    run_line(2, 100);
    gap(4, 1'b1);
    run_line(3, 80);
    gap(4, 1'b1);
    run_line(4, 70);
    gap(4, 1'b1);
    run_line(5, 30);
    gap(4, 1'b1);
    run_line(5, 30);
    gap(4, 1'b1);

    // Mid-line reset at pixel 40
    for (int n = 0; n <= 40; n++) step(1'b1, 6, n, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk);
    #1 check_all_zero("reset_edge");
    #1 rst_n = 1'b1;
    exp_q.delete();
    d1_de = 1'b0; d1_hs = 1'b0; d1_vs = 1'b0;
    gap(4, 1'b0);
    run_line(2, 100);
    gap(3, 1'b0);
    check("leftover_expected", VW'(exp_q.size()), VW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
